// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit: funct3 op codes,
// the M-extension funct7 value, FSM states and operand-signedness helpers.
package muldiv_unit_pkg;

    localparam logic [6:0] INST_FUNCT7_M = 7'b0000001;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic op_signed1(input logic [2:0] op);
        return (op == INST_MULH) || (op == INST_MULHSU) || (op == INST_DIV) || (op == INST_REM);
    endfunction

    function automatic logic op_signed2(input logic [2:0] op);
        return (op == INST_MULH) || (op == INST_DIV) || (op == INST_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign handling around the unsigned iterative core: operand magnitudes and result
// negate flag at accept, plus the final conditional two's-complement negation.
module muldiv_sign_fix
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   op1,
    input  logic [XLEN-1:0]   op2,
    output logic [XLEN-1:0]   mag1,
    output logic [XLEN-1:0]   mag2,
    output logic              neg,
    input  logic [2*XLEN-1:0] fix_in,
    input  logic              fix_neg,
    output logic [2*XLEN-1:0] fix_out
);

    logic sgn1;
    logic sgn2;

    assign sgn1 = op_signed1(op) & op1[XLEN-1];
    assign sgn2 = op_signed2(op) & op2[XLEN-1];

    assign mag1 = sgn1 ? -op1 : op1;
    assign mag2 = sgn2 ? -op2 : op2;

    // Remainder follows the dividend sign; everything else is the product/quotient sign.
    assign neg = (op == INST_REM) ? sgn1 : (sgn1 ^ sgn2);

    // Negation spans the full double-width product so MULH high halves come out right.
    assign fix_out = fix_neg ? -fix_in : fix_in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single cycle at accept.
//
// state   | meaning
// MD_IDLE | ready, waiting for start
// MD_CALC | XLEN iterations of shift-add or restoring divide
// MD_DONE | valid strobe, result and rd_addr_out presented
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      rd_addr_in,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr_out
);

    md_state_e         state;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   opb;
    logic [CNT_W-1:0]  cnt;

    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic              neg_acc;
    logic [2*XLEN-1:0] fix_in;
    logic [2*XLEN-1:0] fix_out;

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .op      (op),
        .op1     (op1),
        .op2     (op2),
        .mag1    (mag1),
        .mag2    (mag2),
        .neg     (neg_acc),
        .fix_in  (fix_in),
        .fix_neg (neg_q),
        .fix_out (fix_out)
    );

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
    assign mul_nxt = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

    // Divide: acc low half holds dividend bits shifting out and quotient bits shifting in.
    // Because rem < divisor, bit XLEN of the trial difference is a clean borrow.
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_diff;
    logic            div_ge;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    assign rem_sh   = {rem, acc[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, opb};
    assign div_ge   = ~rem_diff[XLEN];
    assign rem_nxt  = div_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nxt  = {acc[XLEN-2:0], div_ge};

    logic [XLEN-1:0] res_sel;
    assign fix_in  = op_q[2] ? {{XLEN{1'b0}}, (op_q[1] ? rem_nxt : quo_nxt)} : mul_nxt;
    assign res_sel = (op_q[2] || (op_q == INST_MUL)) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];

    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] spec_res;
    assign div0     = (op2 == '0);
    assign ovf      = ((op == INST_DIV) || (op == INST_REM)) &&
                      (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    assign spec_res = div0 ? (op[1] ? op1 : '1) : (op[1] ? '0 : op1);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fm_a;
    logic signed [XLEN:0]     fm_b;
    logic signed [2*XLEN+1:0] fm_p;
    logic [XLEN-1:0]          fm_res;
    assign fm_a   = $signed({op_signed1(op) & op1[XLEN-1], op1});
    assign fm_b   = $signed({op_signed2(op) & op2[XLEN-1], op2});
    assign fm_p   = fm_a * fm_b;
    assign fm_res = (op == INST_MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
`endif

    assign ready = (state == MD_IDLE);
    assign busy  = (state != MD_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= MD_IDLE;
            op_q        <= '0;
            neg_q       <= 1'b0;
            acc         <= '0;
            rem         <= '0;
            opb         <= '0;
            cnt         <= '0;
            valid       <= 1'b0;
            result      <= '0;
            rd_addr_out <= '0;
        end else begin
            valid <= 1'b0;
            if (flush) begin
                state <= MD_IDLE;
            end else begin
                case (state)
                    MD_IDLE: begin
                        if (start) begin
                            op_q        <= op;
                            neg_q       <= neg_acc;
                            rd_addr_out <= rd_addr_in;
                            cnt         <= '0;
                            rem         <= '0;
                            opb         <= op[2] ? mag2 : mag1;
                            acc         <= {{XLEN{1'b0}}, (op[2] ? mag1 : mag2)};
                            if (op[2] && (div0 || ovf)) begin
                                result <= spec_res;
                                valid  <= 1'b1;
                                state  <= MD_DONE;
`ifdef MULDIV_FAST_MUL_EN
                            end else if (!op[2]) begin
                                result <= fm_res;
                                valid  <= 1'b1;
                                state  <= MD_DONE;
`endif
                            end else begin
                                state <= MD_CALC;
                            end
                        end
                    end
                    MD_CALC: begin
                        if (op_q[2]) begin
                            acc[XLEN-1:0] <= quo_nxt;
                            rem           <= rem_nxt;
                        end else begin
                            acc <= mul_nxt;
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(XLEN - 1)) begin
                            result <= res_sel;
                            valid  <= 1'b1;
                            state  <= MD_DONE;
                        end
                    end
                    MD_DONE: state <= MD_IDLE;
                    default: state <= MD_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: an arithmetic reference model checked every
// cycle, plus directed vectors with literal expectations (honours MULDIV_FAST_MUL_EN).
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd_addr_in;
    logic        flush;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic [4:0]  rd_addr_out;

    int checks = 0;
    int passed = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .op1         (op1),
        .op2         (op2),
        .rd_addr_in  (rd_addr_in),
        .flush       (flush),
        .ready       (ready),
        .busy        (busy),
        .valid       (valid),
        .result      (result),
        .rd_addr_out (rd_addr_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // RV32M semantics straight from 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            INST_MUL:    begin sp = sa * sb; return sp[31:0]; end
            INST_MULH:   begin sp = sa * sb; return sp[63:32]; end
            INST_MULHSU: begin sp = sa * longint'(ub); return sp[63:32]; end
            INST_MULHU:  begin up = ua * ub; return up[63:32]; end
            INST_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                sp = sa / sb; return sp[31:0];
            end
            INST_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            INST_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sp = sa % sb; return sp[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2]) begin
            if (b == 0) return 1;
            if ((o == INST_DIV || o == INST_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return MUL_LAT;
    endfunction

    // Reference model: tracks one in-flight op and checks outputs every cycle.
    bit          m_busy = 0;
    int          m_cyc;
    int          m_lat;
    logic [31:0] m_res;
    logic [4:0]  m_rd;
    bit          m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0;
        end else begin
            if (flush) begin
                m_busy = 0;
            end else if (m_busy) begin
                m_cyc++;
                if (m_cyc > m_lat) m_busy = 0;
            end else if (start) begin
                m_busy = 1;
                m_cyc  = 1;
                m_lat  = lat_of(op, op1, op2);
                m_res  = model(op, op1, op2);
                m_rd   = rd_addr_in;
            end
            #1;
            m_valid = m_busy && (m_cyc == m_lat);
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("ready", {31'd0, ready}, {31'd0, !m_busy});
            check("valid", {31'd0, valid}, {31'd0, m_valid});
            if (m_valid) begin
                check("model_result", result, m_res);
                check("model_rd", {27'd0, rd_addr_out}, {27'd0, m_rd});
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        start = 1; op = o; op1 = a; op2 = b; rd_addr_in = rd;
        @(negedge clk);
        start = 0;
    endtask

    // Leaves the bench at the negedge of the valid cycle so the next issue is back-to-back.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
        int n;
        check({name, "_model"}, model(o, a, b), exp);
        issue(o, a, b, rd);
        n = 1;
        while (!valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_seen"}, {31'd0, valid}, 32'd1);
        check({name, "_result"}, result, exp);
        check({name, "_rd"}, {27'd0, rd_addr_out}, {27'd0, rd});
        check({name, "_latency"}, n, exp_lat);
    endtask

    int n_valid;

    initial begin
        clk = 0; rst = 1; start = 0; flush = 0;
        op = 0; op1 = 0; op2 = 0; rd_addr_in = 0;
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", {27'd0, rd_addr_out}, 32'd0);
        #20;
        @(negedge clk);
        rst = 0;

        run_op("mul",      INST_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh",     INST_MULH,   32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000, MUL_LAT);
        run_op("mulhu",    INST_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, MUL_LAT);
        run_op("mulhsu",   INST_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, MUL_LAT);
        run_op("mulh_neg", INST_MULH,   32'hFFFF_FFFD,  32'd5,         5'd5,  32'hFFFF_FFFF, MUL_LAT);
        run_op("mulhu_2",  INST_MULHU,  32'h8000_0000,  32'd4,         5'd6,  32'd2,         MUL_LAT);
        run_op("div",      INST_DIV,    32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 33);
        run_op("rem",      INST_REM,    32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 33);
        run_op("divu",     INST_DIVU,   32'd100,        32'd7,         5'd9,  32'd14,        33);
        run_op("remu",     INST_REMU,   32'd100,        32'd7,         5'd10, 32'd2,         33);
        run_op("div_nn",   INST_DIV,    32'hFFFF_FF9C,  32'hFFFF_FFF9, 5'd11, 32'd14,        33);
        run_op("rem_nn",   INST_REM,    32'hFFFF_FF9C,  32'hFFFF_FFF9, 5'd12, 32'hFFFF_FFFE, 33);
        run_op("divu_sm",  INST_DIVU,   32'd3,          32'd10,        5'd13, 32'd0,         33);
        run_op("div0",     INST_DIV,    32'd5,          32'd0,         5'd14, 32'hFFFF_FFFF, 1);
        run_op("remu0",    INST_REMU,   32'd5,          32'd0,         5'd15, 32'd5,         1);
        run_op("div_ovf",  INST_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
        run_op("rem_ovf",  INST_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'd0,         1);

        // Model-only vectors, including back-to-back issue.
        for (int i = 0; i < 8; i++) begin
            int n;
            issue(3'(i), $urandom, (i == 5) ? 32'd0 : $urandom, 5'(i + 20));
            n = 1;
            while (!valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("rand_seen", {31'd0, valid}, 32'd1);
        end

        // Flush in cycle 10 of a divide.
        issue(INST_DIV, 32'd1000, 32'd7, 5'd9);
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_ready", {31'd0, ready}, 32'd1);
        n_valid = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) n_valid++;
        end
        check("flush_no_valid", n_valid, 0);

        // start together with flush is not accepted.
        @(negedge clk);
        start = 1; flush = 1; op = INST_DIVU; op1 = 32'd50; op2 = 32'd5;
        @(negedge clk);
        start = 0; flush = 0;
        check("startflush_busy", {31'd0, busy}, 32'd0);
        run_op("divu_after", INST_DIVU, 32'd9, 32'd3, 5'd30, 32'd3, 33);

        // Asynchronous reset mid-CALC.
        issue(INST_DIV, 32'd1000, 32'd3, 5'd31);
        repeat (10) @(negedge clk);
        #2 rst = 1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ready", {31'd0, ready}, 32'd1);
        check("arst_valid", {31'd0, valid}, 32'd0);
        check("arst_result", result, 32'd0);
        #1 rst = 0;
        run_op("mul_after_rst", INST_MUL, 32'd3, 32'd4, 5'd7, 32'd12, MUL_LAT);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the execute stage. Ops are R-type with opcode `INST_TYPE_R_M` and funct7 = 7'b0000001; the decoder routes them here instead of the single-cycle ALU. The unit's `busy` output is ORed into `hold_en` toward ctrl, so the pipeline stalls until `valid` pulses. Width is parametrised, and a compile-time option selects a single-cycle multiplier.

## Interface

Parameters:
- XLEN, 32, operand/result width; even, ≥ 8
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when `ready`=1
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op1  in  XLEN  rs1 value (dividend / multiplicand)
- op2  in  XLEN  rs2 value (divisor / multiplier)
- rd_addr_in  in  5  destination register, captured on accept
- flush  in  1  abort in-flight op (jump taken upstream)
- ready  out  1  unit idle, can accept
- busy  out  1  op in flight; drives hold
- valid  out  1  one-cycle result strobe
- result  out  XLEN  result, meaningful when `valid`=1
- rd_addr_out  out  5  captured `rd_addr_in`

## Operation

- FSM states: IDLE, CALC, DONE. `ready` = (state==IDLE). `busy` = (state!=IDLE).
- **Accept.** In IDLE, `start`=1 and `flush`=0 at a clock edge latch `op`, `rd_addr_in`, and operand magnitudes.
  - Signed ops (MULH, DIV, REM, and op1 of MULHSU): take the two's-complement absolute value.
  - Record the result-negate flag.
- **Special cases**, decided at accept; go directly to DONE:
  - Divide by zero (op2==0): DIV/DIVU → all-ones; REM/REMU → op1.
  - Signed overflow (DIV/REM, op1 = 1<<(XLEN-1), op2 = all-ones): DIV → op1; REM → 0.
- **CALC**, exactly XLEN cycles, counter 0..XLEN-1:
  - Multiply: shift-add, one multiplier bit per cycle, into a 2·XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle. Remainder is XLEN+1 bits for the trial subtract.
- **Result selection** on the last CALC cycle, applying negation:
  - MUL → low XLEN bits of the product; MULH/MULHSU/MULHU → high XLEN bits.
  - DIV/DIVU → quotient; REM/REMU → remainder.
  - Quotient sign = op1 sign XOR op2 sign. Remainder sign = op1 sign.
- **DONE:** `valid`=1 and `result`/`rd_addr_out` valid for exactly one cycle, then return to IDLE.
- `start` while not IDLE is ignored; there is no queue.
- `flush`=1 in any state → IDLE on the next edge, no `valid`. `flush` beats `start` in the same cycle.
- Reset (async, any state) → IDLE.
  - Reset values: `valid`=0, `result`=0, `rd_addr_out`=0, `busy`=0, `ready`=1.
  - All internal registers are cleared to 0.

## Timing

- Accept at edge 0.
- Iterative path: CALC for cycles 1..XLEN; `valid` high in cycle XLEN+1. Latency is XLEN+1 cycles (33 at XLEN=32).
- Special case or fast multiply: `valid` high in cycle 1 (latency 1).
- `busy` rises the cycle after accept and falls the cycle after the `valid` cycle. Ctrl sees hold throughout, including the `valid` cycle.
- Back-to-back: the next accept is possible in the cycle after `valid`.
- `result` holds its value after `valid` until the next DONE; consumers must sample only on `valid`.

## Configuration

- Macro: `MULDIV_FAST_MUL_EN`.
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle signed (XLEN+1)×(XLEN+1) product computed at accept and go IDLE→DONE (latency 1). Divide is unchanged.
- Undefined: all multiplies use the XLEN-cycle shift-add path. No DSP-style multiplier is inferred.

## Structure

- Shared package / header `defines.v` holds:
  - op encodings `INST_MUL` … `INST_REMU` and `INST_FUNCT7_M` = 7'b0000001;
  - FSM state encodings `MD_IDLE`, `MD_CALC`, `MD_DONE`.
- One natural sub-module, `muldiv_sign_fix` (combinational):
  - operand magnitude plus sign flag per op;
  - final conditional negation.
- FSM and iterative datapath stay in `muldiv_unit`.

## Test plan

Values assume XLEN=32.
- MUL op1=7, op2=0xFFFFFFFD → `valid` in cycle 33 (cycle 1 with `MULDIV_FAST_MUL_EN`), `result`=0xFFFFFFEB; `busy` high cycles 1–33.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each `valid` in cycle 33 with `rd_addr_out` = captured rd.
- Special cases: DIV 5/0 → 0xFFFFFFFF in cycle 1; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Flush: `flush` at cycle 10 of a DIV → `busy`=0, `ready`=1 next cycle, no `valid` ever. `start`+`flush` together in IDLE → not accepted. A new DIVU 9/3 issued afterwards → 3.
- Reset: `rst` asserted mid-CALC, between edges → `busy`=0, `ready`=1, `valid`=0, `result`=0 immediately. After release, MUL 3×4 → 12.
